// File: rtl/arb_cmd_sequencer.sv
// arb_cmd_sequencer: drives a fixed arbiter command sequence, advancing on each grant rising edge.
// Optional macro SEQ_TIMEOUT_EN adds a grant-wait timeout that parks the sequencer in ERR.
module arb_cmd_sequencer #(
    parameter int                CMD_W    = 6,
    parameter int                SEQ_LEN  = 33,
    parameter int                TIMEOUT  = 64,
    parameter logic [CMD_W-1:0]  IDLE_CMD = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             grant_i,
    output logic [CMD_W-1:0] cmd_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [5:0]       cmd_idx_o,
    output logic [7:0]       grant_cnt_o
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;

    state_t state;
    logic   grant_q;
    logic   grant_edge;
    logic   last;

    assign grant_edge = grant_i & ~grant_q;
    assign last       = cmd_idx_o == 6'(SEQ_LEN - 1);

    function automatic logic [CMD_W-1:0] rom(input logic [5:0] i);
        logic [CMD_W-1:0] r;
        case (i)
            6'd0:  r = CMD_W'(1);
            6'd1:  r = CMD_W'(2);
            6'd2:  r = CMD_W'(3);
            6'd3:  r = CMD_W'(4);
            6'd4:  r = CMD_W'(5);
            6'd5:  r = CMD_W'(6);
            6'd6:  r = CMD_W'(7);
            6'd7:  r = CMD_W'(8);
            6'd8:  r = CMD_W'(13);
            6'd9:  r = CMD_W'(18);
            6'd10: r = CMD_W'(23);
            6'd11: r = CMD_W'(28);
            6'd12: r = CMD_W'(12);
            6'd13: r = CMD_W'(9);
            6'd14: r = CMD_W'(19);
            6'd15: r = CMD_W'(29);
            6'd16: r = CMD_W'(17);
            6'd17: r = CMD_W'(14);
            6'd18: r = CMD_W'(24);
            6'd19: r = CMD_W'(10);
            6'd20: r = CMD_W'(26);
            6'd21: r = CMD_W'(22);
            6'd22: r = CMD_W'(21);
            6'd23: r = CMD_W'(16);
            6'd24: r = CMD_W'(11);
            6'd25: r = CMD_W'(32);
            6'd26: r = CMD_W'(31);
            6'd27: r = CMD_W'(27);
            6'd28: r = CMD_W'(25);
            6'd29: r = CMD_W'(15);
            6'd30: r = CMD_W'(30);
            6'd31: r = CMD_W'(20);
            6'd32: r = CMD_W'(7);
            default: r = IDLE_CMD;
        endcase
        return r;
    endfunction

`ifdef SEQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT) > 0 ? $clog2(TIMEOUT) : 1;
    logic [WW-1:0] wait_cnt;
`else
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cmd_o       <= IDLE_CMD;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            cmd_idx_o   <= '0;
            grant_cnt_o <= '0;
            grant_q     <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            timeout_o   <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            grant_q <= grant_i;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state       <= WAIT;
                        cmd_idx_o   <= '0;
                        cmd_o       <= rom(6'd0);
                        busy_o      <= 1'b1;
                        done_o      <= 1'b0;
                        grant_cnt_o <= '0;
`ifdef SEQ_TIMEOUT_EN
                        timeout_o   <= 1'b0;
                        wait_cnt    <= '0;
`endif
                    end
                end
                WAIT: begin
                    // An edge always wins, even in the cycle the wait would expire.
                    if (grant_edge) begin
                        grant_cnt_o <= grant_cnt_o + {7'd0, grant_cnt_o != 8'hFF};
`ifdef SEQ_TIMEOUT_EN
                        wait_cnt    <= '0;
`endif
                        if (last) begin
                            state  <= DONE;
                            cmd_o  <= IDLE_CMD;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end else begin
                            cmd_idx_o <= cmd_idx_o + 6'd1;
                            cmd_o     <= rom(cmd_idx_o + 6'd1);
                        end
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                        state     <= ERR;
                        timeout_o <= 1'b1;
                        busy_o    <= 1'b0;
                        cmd_o     <= IDLE_CMD;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_arb_cmd_sequencer.sv
// tb_arb_cmd_sequencer: directed vector table plus hand sequences for arb_cmd_sequencer.
module tb_arb_cmd_sequencer;
    logic       clk = 1'b0, rst = 1'b0, start = 1'b0, grant_i = 1'b0;
    logic [5:0] cmd_o, cmd_idx_o;
    logic       busy_o, done_o, timeout_o;
    logic [7:0] grant_cnt_o;
    int total = 0, bad = 0;
    int tab[33] = '{1,2,3,4,5,6,7,8,13,18,23,28,12,9,19,29,17,14,24,10,26,22,21,16,11,32,31,27,25,15,30,20,7};

    typedef struct {
        logic       s;
        logic       g;
        logic [5:0] cmd;
        logic [5:0] idx;
        logic       busy;
        logic       done;
        logic [7:0] cnt;
    } vec_t;
    vec_t vt[7];

    always #5 clk = ~clk;

    arb_cmd_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .grant_i(grant_i),
        .cmd_o(cmd_o), .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
        .cmd_idx_o(cmd_idx_o), .grant_cnt_o(grant_cnt_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_grant;
        grant_i = 1'b1;
        @(negedge clk);
        grant_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic begin_seq;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Reset asserted between edges; outputs must clear before any clock edge.
    task automatic rst_chk(input string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, "_cmd"}, cmd_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_tmo"}, timeout_o, 0);
        chk({tag, "_idx"}, cmd_idx_o, 0);
        chk({tag, "_cnt"}, grant_cnt_o, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vt[0] = '{1'b1, 1'b0, 6'd1, 6'd0, 1'b1, 1'b0, 8'd0};
        vt[1] = '{1'b0, 1'b1, 6'd2, 6'd1, 1'b1, 1'b0, 8'd1};
        vt[2] = '{1'b0, 1'b1, 6'd2, 6'd1, 1'b1, 1'b0, 8'd1};
        vt[3] = '{1'b0, 1'b0, 6'd2, 6'd1, 1'b1, 1'b0, 8'd1};
        vt[4] = '{1'b1, 1'b1, 6'd3, 6'd2, 1'b1, 1'b0, 8'd2};
        vt[5] = '{1'b1, 1'b0, 6'd3, 6'd2, 1'b1, 1'b0, 8'd2};
        vt[6] = '{1'b0, 1'b1, 6'd4, 6'd3, 1'b1, 1'b0, 8'd3};

        #1;
        rst_chk("por");
        for (int i = 0; i < 7; i++) begin
            start = vt[i].s;
            grant_i = vt[i].g;
            @(negedge clk);
            chk($sformatf("vec%0d_cmd", i), cmd_o, vt[i].cmd);
            chk($sformatf("vec%0d_idx", i), cmd_idx_o, vt[i].idx);
            chk($sformatf("vec%0d_busy", i), busy_o, vt[i].busy);
            chk($sformatf("vec%0d_done", i), done_o, vt[i].done);
            chk($sformatf("vec%0d_cnt", i), grant_cnt_o, vt[i].cnt);
        end
        start = 1'b0;
        grant_i = 1'b0;

        // Full run through all table entries.
        rst_chk("rst_full");
        begin_seq;
        chk("full_cmd0", cmd_o, tab[0]);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("full_idx%0d", i), cmd_idx_o, i);
            cyc(2);
            chk($sformatf("full_hold%0d", i), cmd_o, tab[i]);
            pulse_grant;
            chk($sformatf("full_cmd%0d", i + 1), cmd_o, tab[i + 1]);
        end
        chk("full_idx32", cmd_idx_o, 32);
        cyc(2);
        pulse_grant;
        chk("end_done", done_o, 1);
        chk("end_cmd", cmd_o, 0);
        chk("end_busy", busy_o, 0);
        chk("end_cnt", grant_cnt_o, 33);
        chk("end_idx", cmd_idx_o, 32);
        pulse_grant;
        chk("done_ignore_edge_cnt", grant_cnt_o, 33);
        begin_seq;
        chk("restart_cmd", cmd_o, 1);
        chk("restart_done", done_o, 0);
        chk("restart_busy", busy_o, 1);
        chk("restart_cnt", grant_cnt_o, 0);

        // Held grant counts once.
        rst_chk("rst_held");
        begin_seq;
        grant_i = 1'b1;
        cyc(10);
        grant_i = 1'b0;
        cyc(1);
        chk("held_cmd", cmd_o, 2);
        chk("held_idx", cmd_idx_o, 1);
        chk("held_cnt", grant_cnt_o, 1);

        // Start while sequencing is ignored.
        repeat (4) pulse_grant;
        chk("ign_pre_idx", cmd_idx_o, 5);
        begin_seq;
        cyc(1);
        chk("ign_idx", cmd_idx_o, 5);
        chk("ign_cmd", cmd_o, 6);
        chk("ign_cnt", grant_cnt_o, 5);

        // Grant withheld at entry 3.
        rst_chk("rst_tmo");
        begin_seq;
        repeat (3) pulse_grant;
        chk("tmo_pre_cmd", cmd_o, 4);
`ifdef SEQ_TIMEOUT_EN
        cyc(62);
        chk("tmo_early", timeout_o, 0);
        chk("tmo_early_busy", busy_o, 1);
        cyc(1);
        chk("tmo_flag", timeout_o, 1);
        chk("tmo_busy", busy_o, 0);
        chk("tmo_cmd", cmd_o, 0);
        chk("tmo_idx", cmd_idx_o, 3);
        begin_seq;
        chk("tmo_restart_cmd", cmd_o, 1);
        chk("tmo_restart_flag", timeout_o, 0);
`else
        cyc(200);
        chk("stall_busy", busy_o, 1);
        chk("stall_tmo", timeout_o, 0);
        chk("stall_cmd", cmd_o, 4);
        chk("stall_idx", cmd_idx_o, 3);
`endif

        // Mid-run reset at entry 20.
        rst_chk("rst_mid_pre");
        begin_seq;
        repeat (20) pulse_grant;
        chk("mid_idx", cmd_idx_o, 20);
        rst_chk("mid");
        begin_seq;
        chk("mid_restart_cmd", cmd_o, 1);
        chk("mid_restart_idx", cmd_idx_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
